// File: rtl/spi_reg_slave.sv
// Clk-oversampled SPI slave giving register read/write access with selectable CPOL/CPHA.
// Optional SPI_BURST_EN: auto-incrementing multi-word bursts that run until cs_n rises.
module spi_reg_slave #(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);
  localparam int unsigned CMD_W    = ADDR_W + 1;
  localparam int unsigned MAX_BITS = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic        IDLE_LVL = 1'(CPOL);

  typedef enum logic [2:0] {IDLE, CMD, RD_DATA, WR_DATA, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CMD_W-1:0]       cmd_q, cmd_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   miso_q, miso_d;
  logic                   rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;

  logic sclk_s, mosi_s, cs_s;
  logic lead_c, trail_c, sample_c, shift_c, cs_fall_c, cs_rise_c;

  // Synchronisers and edge strobes; cs chain resets low so a frame already running at reset release is ignored
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    lead_c      = (sclk_s != sclk_prev_q) && (sclk_prev_q == IDLE_LVL);
    trail_c     = (sclk_s != sclk_prev_q) && (sclk_prev_q != IDLE_LVL);
    sample_c    = (CPHA == 0) ? lead_c : trail_c;
    shift_c     = (CPHA == 0) ? trail_c : lead_c;
    cs_fall_c   = cs_prev_q && !cs_s;
    cs_rise_c   = !cs_prev_q && cs_s;
  end

  // Frame FSM: command, then read or write data word(s)
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (cs_rise_c) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall_c) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            cmd_d     = '0;
          end
        end
        CMD: begin
          if (sample_c) begin
            cmd_d = CMD_W'({cmd_q, mosi_s});
            if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
              bit_cnt_d = '0;
              addr_d    = cmd_d[ADDR_W-1:0];
              if (cmd_d[CMD_W-1]) begin
                state_d   = RD_DATA;
                rd_req_d  = 1'b1;
                rd_addr_d = cmd_d[ADDR_W-1:0];
              end else begin
                state_d = WR_DATA;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        RD_DATA: begin
          if (rd_req_q) begin
            shreg_d = rd_data;
          end else if (shift_c && (bit_cnt_q != CNT_W'(DATA_W))) begin
            miso_d  = shreg_q[DATA_W-1];
            shreg_d = DATA_W'({shreg_q, 1'b0});
`ifdef SPI_BURST_EN
            // Prefetch the next word while its predecessor's last bit is on the wire
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + ADDR_W'(1);
              rd_req_d  = 1'b1;
              rd_addr_d = addr_q + ADDR_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
`else
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
`endif
          end else if (sample_c && (bit_cnt_q == CNT_W'(DATA_W))) begin
            state_d = DONE;
          end
        end
        WR_DATA: begin
          if (sample_c) begin
            shreg_d = DATA_W'({shreg_q, mosi_s});
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = shreg_d;
              bit_cnt_d = '0;
`ifdef SPI_BURST_EN
              addr_d    = addr_q + ADDR_W'(1);
`else
              state_d   = DONE;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    if (state_d != RD_DATA) miso_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_prev_q <= IDLE_LVL;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      shreg_q     <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign miso    = miso_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: one instance per SPI mode, a bench-side register bank and a
// transaction-level model (expected write/read queues plus model memory) checked every clk.
`timescale 1ns/1ps
module tb_spi_reg_slave;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int NI     = 4;
  localparam int T_HALF = 80;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n, mosi, cs_n;
  logic [NI-1:0]     sclk_v, miso_v, rd_req_v, wr_en_v, busy_v;
  logic [ADDR_W-1:0] rd_addr_v [NI];
  logic [ADDR_W-1:0] wr_addr_v [NI];
  logic [DATA_W-1:0] wr_data_v [NI];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] bank      [4];
  logic [DATA_W-1:0] model_mem [4];
  logic [ADDR_W-1:0] held_ra   [NI];
  logic [ADDR_W-1:0] held_wa   [NI];
  logic [DATA_W-1:0] held_wd   [NI];
  wr_t               exp_wr [$];
  logic [ADDR_W-1:0] exp_rd [$];
  int act;
  bit reading;
  int n_chk, n_fail, wr_cnt, rd_cnt;

  always #5 clk = ~clk;

  // Instance g runs SPI mode g: CPOL = g[1], CPHA = g[0]
  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_reg_slave #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[g]), .mosi(mosi), .cs_n(cs_n),
      .miso(miso_v[g]), .rd_req(rd_req_v[g]), .rd_addr(rd_addr_v[g]), .rd_data(rd_data),
      .wr_en(wr_en_v[g]), .wr_addr(wr_addr_v[g]), .wr_data(wr_data_v[g]), .busy(busy_v[g])
    );
  end

  // Register bank behind the active instance
  always @(posedge clk) if (rst_n && wr_en_v[act]) bank[wr_addr_v[act]] <= wr_data_v[act];
  assign rd_data = bank[rd_addr_v[act]];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the transaction model
  always @(negedge clk) begin : cmp
    wr_t e;
    logic [ADDR_W-1:0] ea;
    if (!rst_n) begin
      for (int g = 0; g < NI; g++) begin
        held_ra[g] = '0; held_wa[g] = '0; held_wd[g] = '0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (!busy_v[g] || g != act || !reading) chk("miso_quiet", 32'(miso_v[g]), 32'd0);
        if (g != act) begin
          chk("stray_wr_en", 32'(wr_en_v[g]), 32'd0);
          chk("stray_rd_req", 32'(rd_req_v[g]), 32'd0);
        end else begin
          if (wr_en_v[g]) begin
            wr_cnt++;
            chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
              e = exp_wr.pop_front();
              held_wa[g] = e.a;
              held_wd[g] = e.d;
            end
          end
          if (rd_req_v[g]) begin
            rd_cnt++;
            chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) begin
              ea = exp_rd.pop_front();
              held_ra[g] = ea;
            end
          end
        end
        chk("wr_addr", 32'(wr_addr_v[g]), 32'(held_wa[g]));
        chk("wr_data", 32'(wr_data_v[g]), 32'(held_wd[g]));
        chk("rd_addr", 32'(rd_addr_v[g]), 32'(held_ra[g]));
      end
    end
  end

  task automatic cs_low();
    cs_n = 1'b0;
    #(T_HALF);
  endtask

  task automatic cs_high();
    #(T_HALF);
    cs_n = 1'b1;
    #(4 * T_HALF);
  endtask

  // Master side: n bits MSB first in the active mode; optionally raise cs_n on the last sample edge
  task automatic xfer_bits(input int n, input logic [31:0] tx, input bit cs_on_last,
                           output logic [31:0] rx);
    logic cpol, cpha;
    cpol = act[1];
    cpha = act[0];
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        #(T_HALF);
        rx = {rx[30:0], miso_v[act]};
        sclk_v[act] = ~cpol;
        if (cs_on_last && i == 0) cs_n = 1'b1;
        #(T_HALF);
        sclk_v[act] = cpol;
      end else begin
        sclk_v[act] = ~cpol;
        mosi = tx[i];
        #(T_HALF);
        rx = {rx[30:0], miso_v[act]};
        sclk_v[act] = cpol;
        if (cs_on_last && i == 0) cs_n = 1'b1;
        #(T_HALF);
      end
    end
  endtask

  task automatic drained(input string name);
    chk({name, "_wr_drained"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_rd_drained"}, 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [31:0] rx;
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
    model_mem[a] = d;
    cs_low();
    xfer_bits(3, {29'd0, 1'b0, a}, 1'b0, rx);
    xfer_bits(8, {24'd0, d}, 1'b0, rx);
    cs_high();
    drained("wr");
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    logic [31:0] rx;
    exp_rd.push_back(a);
`ifdef SPI_BURST_EN
    exp_rd.push_back(ADDR_W'(a + 2'd1));
`endif
    reading = 1'b1;
    cs_low();
    xfer_bits(3, {29'd0, 1'b1, a}, 1'b0, rx);
    xfer_bits(8, 32'd0, 1'b0, rx);
    cs_high();
    reading = 1'b0;
    d = rx[7:0];
    chk("rd_word", 32'(d), 32'(model_mem[a]));
    drained("rd");
  endtask

  initial begin : main
    logic [DATA_W-1:0] rxb;
    logic [31:0] rx;
    int w0, r0;
    int modes [3];
    n_chk = 0; n_fail = 0; wr_cnt = 0; rd_cnt = 0;
    act = 1; reading = 1'b0;
    rst_n = 1'b0; cs_n = 1'b1; mosi = 1'b0; sclk_v = 4'b1100;
    modes = '{0, 2, 3};
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++)
      chk("reset_outputs", 32'({miso_v[g], rd_req_v[g], rd_addr_v[g], wr_en_v[g],
                                wr_addr_v[g], wr_data_v[g], busy_v[g]}), 32'd0);

    // Write 0xA5 to addr 2
    w0 = wr_cnt;
    do_write(2'd2, 8'hA5);
    chk("wr_count_one", 32'(wr_cnt - w0), 32'd1);
    chk("wr_addr_lit", 32'(wr_addr_v[1]), 32'd2);
    chk("wr_data_lit", 32'(wr_data_v[1]), 32'hA5);

    // Read addr 1 holding 0x3C
    do_write(2'd1, 8'h3C);
    r0 = rd_cnt;
    do_read(2'd1, rxb);
    chk("rd_word_lit", 32'(rxb), 32'h3C);
    chk("rd_addr_lit", 32'(rd_addr_v[1]), 32'd1);
`ifndef SPI_BURST_EN
    chk("rd_count_one", 32'(rd_cnt - r0), 32'd1);
`endif

    // Other SPI modes: write 0x5A to addr 3 and read it back
    foreach (modes[k]) begin
      act = 1;
      do_write(2'd3, 8'h00);
      act = modes[k];
      do_write(2'd3, 8'h5A);
      do_read(2'd3, rxb);
      chk("mode_rd_lit", 32'(rxb), 32'h5A);
    end
    act = 1;

    // Abort after 5 of 8 write data bits
    w0 = wr_cnt;
    cs_low();
    xfer_bits(3, 32'b000, 1'b0, rx);
    xfer_bits(5, 32'b10110, 1'b0, rx);
    @(negedge clk);
    chk("busy_mid_frame", 32'(busy_v[1]), 32'd1);
    cs_high();
    chk("busy_after_abort", 32'(busy_v[1]), 32'd0);
    chk("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
    do_write(2'd0, 8'h96);
    chk("wr_after_abort", 32'(wr_cnt - w0), 32'd1);
    do_read(2'd0, rxb);
    chk("rd_after_abort_lit", 32'(rxb), 32'h96);

    // cs_n rises together with the last write sample edge
    w0 = wr_cnt;
    cs_low();
    xfer_bits(3, 32'b011, 1'b0, rx);
    xfer_bits(8, 32'hC3, 1'b1, rx);
    cs_high();
    chk("cs_wins_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("cs_wins_idle", 32'(busy_v[1]), 32'd0);
    do_read(2'd3, rxb);
    chk("cs_wins_mem_lit", 32'(rxb), 32'h5A);

    // Reset pulse in the middle of a read
    exp_rd.push_back(2'd1);
    reading = 1'b1;
    cs_low();
    xfer_bits(3, 32'b101, 1'b0, rx);
    xfer_bits(4, 32'd0, 1'b0, rx);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_read", 32'({miso_v[1], rd_req_v[1], rd_addr_v[1], wr_en_v[1],
                               wr_addr_v[1], wr_data_v[1], busy_v[1]}), 32'd0);
    #29;
    rst_n = 1'b1;
    w0 = wr_cnt;
    r0 = rd_cnt;
    xfer_bits(4, 32'd0, 1'b0, rx);
    xfer_bits(8, 32'hFF, 1'b0, rx);
    cs_high();
    reading = 1'b0;
    chk("post_reset_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("post_reset_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("post_reset_idle", 32'(busy_v[1]), 32'd0);
    do_read(2'd2, rxb);
    chk("post_reset_rd_lit", 32'(rxb), 32'hA5);

`ifdef SPI_BURST_EN
    begin : burst
      wr_t e;
      logic [31:0] rx0;
      e.a = 2'd3; e.d = 8'h11; exp_wr.push_back(e); model_mem[3] = 8'h11;
      e.a = 2'd0; e.d = 8'h22; exp_wr.push_back(e); model_mem[0] = 8'h22;
      cs_low();
      xfer_bits(3, 32'b011, 1'b0, rx);
      xfer_bits(8, 32'h11, 1'b0, rx);
      xfer_bits(8, 32'h22, 1'b0, rx);
      cs_high();
      drained("burst_wr");
      exp_rd.push_back(2'd3);
      exp_rd.push_back(2'd0);
      exp_rd.push_back(2'd1);
      reading = 1'b1;
      cs_low();
      xfer_bits(3, 32'b111, 1'b0, rx);
      xfer_bits(8, 32'd0, 1'b0, rx0);
      xfer_bits(8, 32'd0, 1'b0, rx);
      cs_high();
      reading = 1'b0;
      chk("burst_rd0_lit", rx0, 32'h11);
      chk("burst_rd1_lit", rx, 32'h22);
      drained("burst_rd");
    end
`endif

    drained("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
